// File: rtl/adc_mem_reader.sv
// Read-back engine for the ADC window of the shared DPRAM: issues sequential reads,
// buffers returns in a small prefetch FIFO and streams samples out on valid/ready.
module adc_mem_reader #(
  parameter int unsigned          ADDR_BITS  = 13,
  parameter logic [ADDR_BITS-1:0] ADDR_START = 13'h800,
  parameter logic [ADDR_BITS-1:0] ADDR_SPAN  = 13'h1000,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 csr_start_i,
  output logic                 csr_done_o,
  output logic                 csr_busy_o,
  output logic                 rd_en_o,
  output logic [ADDR_BITS-1:0] rd_addr_o,
  input  logic [31:0]          rd_data_i,
  output logic [31:0]          m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o
);

  localparam int unsigned    PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned    CNT_W     = ADDR_BITS + 1;
  localparam int unsigned    OCC_W     = PTR_W + 2;
  localparam logic [CNT_W-1:0] SPAN_CNT = CNT_W'(ADDR_SPAN);
  localparam logic [CNT_W-1:0] LAST_IDX = SPAN_CNT - CNT_W'(1);
  // Leaves room for one new read plus one already in flight without overflowing.
  localparam logic [OCC_W-1:0] ISSUE_MAX = OCC_W'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;

  state_t      state;
  logic [CNT_W-1:0] issued;
  logic        inflight;
  logic        inflight_last;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;
  fifo_entry_t fifo_mem [FIFO_DEPTH];
  fifo_entry_t head;

  logic [OCC_W-1:0] occ_sum;
  logic        issue_last;
  logic        push;
  logic        pop;

  // Issue decision uses registered state only, so backpressure never reaches rd_en_o combinationally.
  assign occ_sum    = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign rd_en_o    = (state == S_RUNNING) && (issued < SPAN_CNT) && (occ_sum <= ISSUE_MAX);
  assign issue_last = (issued == LAST_IDX);
  assign push       = inflight;
  assign m_valid_o  = (fifo_count != '0);
  assign pop        = m_valid_o && m_ready_i;

  // NOTE: every registered signal uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      csr_done_o    <= 1'b0;
      csr_busy_o    <= 1'b0;
      rd_addr_o     <= ADDR_START;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      inflight      <= rd_en_o;
      inflight_last <= rd_en_o && issue_last;

      if (rd_en_o) begin
        issued <= issued + CNT_W'(1);
        if (!issue_last) begin
          rd_addr_o <= rd_addr_o + ADDR_BITS'(1);
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        S_IDLE: begin
          if (csr_start_i) begin
            state      <= S_RUNNING;
            csr_busy_o <= 1'b1;
            csr_done_o <= 1'b0;
            rd_addr_o  <= ADDR_START;
            issued     <= '0;
          end
        end
        S_RUNNING: begin
          // A dropped start request is ignored; only the final transfer ends the run.
          if (pop && m_last_o) begin
            state      <= S_DONE;
            csr_busy_o <= 1'b0;
            csr_done_o <= 1'b1;
          end
        end
        S_DONE: begin
          if (!csr_start_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the cleared count/pointers make stale entries invisible.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{last: inflight_last, data: rd_data_i};
    end
  end

  // NOTE: outputs get a default before the conditional so no latch is inferred.
  always_comb begin
    head     = fifo_mem[rd_ptr];
    m_data_o = '0;
    m_last_o = 1'b0;
    if (m_valid_o) begin
      m_data_o = head.data;
      m_last_o = head.last;
    end
  end

endmodule

// File: tb/tb_adc_mem_reader.sv
// Self-checking bench for adc_mem_reader: a 1-cycle-latency RAM model, a stream-level
// reference model checked every cycle, and directed runs with hand-computed milestones.
module tb_adc_mem_reader;

  localparam int SPAN  = 4096;
  localparam int START = 'h800;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        csr_start_i;
  logic        csr_done_o;
  logic        csr_busy_o;
  logic        rd_en_o;
  logic [12:0] rd_addr_o;
  logic [31:0] rd_data_i;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_last_o;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int ready_mode = 0;

  always #5 sys_clk = ~sys_clk;

  adc_mem_reader dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .csr_start_i (csr_start_i),
    .csr_done_o  (csr_done_o),
    .csr_busy_o  (csr_busy_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o)
  );

  function automatic logic [31:0] ram_word(input int addr);
    return 32'(addr) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // DPRAM read port: data for a request appears during the following cycle, junk otherwise.
  bit pend;
  int pend_addr;
  always @(negedge sys_clk) begin
    rd_data_i = pend ? ram_word(pend_addr) : 32'hDEAD_BEEF;
    pend      = (rd_en_o === 1'b1);
    pend_addr = int'(rd_addr_o);
  end

  // Reference model in terms of words read, words returned and words transferred.
  int m_reads, m_pushed, m_xfer;
  bit m_prev_rd, m_active, m_armed, m_done;
  bit exp_valid, exp_rd, last_xfer;
  int exp_addr;

  always @(negedge sys_clk) begin
    exp_valid = (m_pushed - m_xfer) > 0;
    exp_rd    = m_active && (m_reads < SPAN) && ((m_pushed - m_xfer) + int'(m_prev_rd) <= 2);
    exp_addr  = START + ((m_reads < SPAN) ? m_reads : SPAN - 1);
    if (chk_en) begin
      check("busy", 32'(csr_busy_o), 32'(m_active));
      check("done", 32'(csr_done_o), 32'(m_done));
      check("rd_en", 32'(rd_en_o), 32'(exp_rd));
      check("rd_addr", 32'(rd_addr_o), 32'(exp_addr));
      check("m_valid", 32'(m_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        check("m_data", m_data_o, ram_word(START + m_xfer));
        check("m_last", 32'(m_last_o), 32'(m_xfer == SPAN - 1));
      end else begin
        check("m_last_idle", 32'(m_last_o), 32'd0);
      end
    end
    if (sys_rst !== 1'b0) begin
      m_reads = 0; m_pushed = 0; m_xfer = 0; m_prev_rd = 1'b0;
      m_active = 1'b0; m_armed = 1'b1; m_done = 1'b0;
    end else begin
      last_xfer = 1'b0;
      if (exp_valid && m_ready_i) begin
        last_xfer = (m_xfer == SPAN - 1);
        m_xfer++;
      end
      m_pushed += int'(m_prev_rd);
      m_prev_rd = exp_rd;
      if (exp_rd) m_reads++;
      if (!m_active && m_armed && csr_start_i) begin
        m_active = 1'b1; m_done = 1'b0;
        m_reads = 0; m_pushed = 0; m_xfer = 0; m_prev_rd = 1'b0;
      end else if (m_active && last_xfer) begin
        m_active = 1'b0; m_done = 1'b1; m_armed = 1'b0;
      end else if (!m_active && !m_armed && !csr_start_i) begin
        m_armed = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
    case (ready_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'($urandom_range(0, 1));
      default: m_ready_i = 1'b0;
    endcase
  endtask

  task automatic wait_done(input string name, input int budget, inout int n);
    while (csr_done_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, 32'(csr_done_o), 32'd1);
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int k = 0;
    while (m_xfer < target && k < budget) begin
      tick();
      k++;
    end
    check("xfer_reached", 32'(m_xfer >= target), 32'd1);
  endtask

  initial begin
    int n;
    int pulses;
    sys_rst     = 1'b1;
    csr_start_i = 1'b0;
    m_ready_i   = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_addr", 32'(rd_addr_o), 32'h800);
    check("rst_valid", 32'(m_valid_o), 32'd0);
    check("rst_data", m_data_o, 32'd0);
    check("rst_done", 32'(csr_done_o), 32'd0);
    sys_rst = 1'b0;
    tick();

    // Run 1: full speed; milestones pin issue/return latency and throughput.
    csr_start_i = 1'b1;
    n = 0;
    tick(); n++;
    check("t1_c1_rd_en", 32'(rd_en_o), 32'd1);
    check("t1_c1_addr", 32'(rd_addr_o), 32'h800);
    check("t1_c1_busy", 32'(csr_busy_o), 32'd1);
    tick(); n++;
    check("t1_c2_addr", 32'(rd_addr_o), 32'h801);
    check("t1_c2_valid", 32'(m_valid_o), 32'd0);
    tick(); n++;
    check("t1_c3_valid", 32'(m_valid_o), 32'd1);
    check("t1_c3_data", m_data_o, 32'hCE01_DE78);
    wait_done("t1", 6000, n);
    check("t1_cycles", 32'(n), 32'd4099);
    check("t1_last_addr", 32'(rd_addr_o), 32'h17FF);
    csr_start_i = 1'b0;
    tick();

    // Run 2: random backpressure.
    ready_mode  = 1;
    csr_start_i = 1'b1;
    n = 0;
    tick(); n++;
    wait_done("t2", 30000, n);
    check("t2_xfers", 32'(m_xfer), 32'd4096);
    csr_start_i = 1'b0;
    ready_mode  = 0;
    tick();

    // Run 3: sink stalled from the start.
    ready_mode  = 2;
    m_ready_i   = 1'b0;
    csr_start_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_en_o === 1'b1) pulses++;
    end
    check("t3_pulses", 32'(pulses), 32'd3);
    check("t3_valid", 32'(m_valid_o), 32'd1);
    ready_mode = 0;
    n = 0;
    wait_done("t3", 6000, n);
    csr_start_i = 1'b0;
    tick();

    // Run 4: start held past done must not retrigger.
    csr_start_i = 1'b1;
    n = 0;
    tick(); n++;
    wait_done("t4", 6000, n);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_en_o === 1'b1) pulses++;
    end
    check("t4_no_retrigger", 32'(pulses), 32'd0);
    check("t4_busy_held", 32'(csr_busy_o), 32'd0);
    csr_start_i = 1'b0;
    tick();
    tick();
    check("t4_done_in_idle", 32'(csr_done_o), 32'd1);
    csr_start_i = 1'b1;
    tick();
    check("t4_done_clr", 32'(csr_done_o), 32'd0);
    check("t4_restart_addr", 32'(rd_addr_o), 32'h800);
    check("t4_restart_rd_en", 32'(rd_en_o), 32'd1);

    // Run 5 (same run): start dropped mid-way.
    wait_xfer(100, 1000);
    csr_start_i = 1'b0;
    n = 0;
    wait_done("t5", 6000, n);
    check("t5_xfers", 32'(m_xfer), 32'd4096);
    tick();

    // Run 6: reset mid-run, then a clean run.
    csr_start_i = 1'b1;
    tick();
    wait_xfer(2000, 4000);
    sys_rst     = 1'b1;
    csr_start_i = 1'b0;
    tick();
    check("t6_busy", 32'(csr_busy_o), 32'd0);
    check("t6_done", 32'(csr_done_o), 32'd0);
    check("t6_rd_en", 32'(rd_en_o), 32'd0);
    check("t6_addr", 32'(rd_addr_o), 32'h800);
    check("t6_valid", 32'(m_valid_o), 32'd0);
    check("t6_last", 32'(m_last_o), 32'd0);
    check("t6_data", m_data_o, 32'd0);
    sys_rst = 1'b0;
    tick();
    tick();
    check("t6_flushed", 32'(m_valid_o), 32'd0);
    csr_start_i = 1'b1;
    n = 0;
    tick(); n++;
    wait_done("t6", 6000, n);
    check("t6_cycles", 32'(n), 32'd4099);
    csr_start_i = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
